// File: rtl/cpu8_pkg.sv
// Shared constants and types for the 8-bit CPU register-file write path.
package cpu8_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_REQ  = 3;
  localparam int LOCK_MAX = 16;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority picker: first set bit of valid searching ptr, ptr+1, ... mod N.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with burst lock for the register-file write port.
// wr_* are registered so the register file's negedge write sees stable inputs.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = cpu8_pkg::NUM_REQ,
  parameter int DATA_W   = cpu8_pkg::DATA_W,
  parameter int ADDR_W   = cpu8_pkg::ADDR_W,
  parameter int LOCK_MAX = cpu8_pkg::LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [1:0]                grant_id,
  output logic [2**ADDR_W-1:0]      pend_mask,
  output logic                      lock_timeout
);
  import cpu8_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic             lock_timeout_q, lock_timeout_d;

  logic [NUM_REQ-1:0] owner_mask, arb_valid, arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_lock;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
    return (int'(i) >= NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // While locked, the picker only ever sees the owner's valid bit.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    arb_valid = (state_q == LOCKED) ? (req_valid & owner_mask) : req_valid;
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .valid (arb_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign req_ready = arb_grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    idle_cnt_d     = idle_cnt_q;
    lock_timeout_d = 1'b0;
    wr_en_d        = arb_any;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    grant_id_d     = grant_id_q;
    if (arb_any) begin
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = 2'(arb_idx);
      rr_ptr_d   = rr_next(arb_idx);
    end
    case (state_q)
      ARB: begin
        if (arb_any && sel_lock) begin
          state_d    = LOCKED;
          owner_d    = arb_idx;
          idle_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (arb_any) begin
          idle_cnt_d = '0;
          if (!sel_lock) state_d = ARB;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d        = ARB;
          lock_timeout_d = 1'b1;
          idle_cnt_d     = '0;
          rr_ptr_d       = rr_next(owner_q);
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      idle_cnt_q     <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      grant_id_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      idle_cnt_q     <= idle_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      grant_id_q     <= grant_id_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign grant_id     = grant_id_q;
  assign lock_timeout = lock_timeout_q;

  // Excludes the write already on wr_*; hazard logic checks that separately.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) pend_mask[req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, directed sequences, random traffic vs model.
module tb_regfile_write_arbiter;
  import cpu8_pkg::*;

  localparam int NR = 3;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_lock, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             wr_en, lock_timeout;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [1:0]       grant_id;
  logic [7:0]       pend_mask;

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id),
    .pend_mask(pend_mask), .lock_timeout(lock_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner lock, rotating pointer, count of owner-idle cycles, expected wr_* for next cycle.
  int m_ptr, m_owner, m_idle;
  bit m_locked;
  bit e_wr_en, e_to;
  int e_addr, e_data, e_gid;

  logic [7:0]    rf_dut [8];
  logic [NR-1:0] last_xfer;
  logic [NR-1:0] s_ready;
  logic [7:0]    s_pend;
  logic          s_wr_en, s_to;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic [1:0]    s_gid;

  typedef struct {
    logic [2:0] valid;
    logic [8:0] addr;
    logic [2:0] exp_ready;
    logic [7:0] exp_pend;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_lock[i]          = l;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic m_reset();
    m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0;
    e_wr_en = 0; e_to = 0; e_addr = 0; e_data = 0; e_gid = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    last_xfer = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    int w;
    logic [7:0] ep;
    @(negedge clk);
    s_ready = req_ready; s_pend = pend_mask; s_wr_en = wr_en; s_to = lock_timeout;
    s_wr_addr = wr_addr; s_wr_data = wr_data; s_gid = grant_id;
    w = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) w = m_owner;
    end else begin
      for (int k = 0; k < NR; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
    end
    ep = '0;
    for (int i = 0; i < NR; i++) if (req_valid[i]) ep = ep | (8'd1 << req_addr[i*AW +: AW]);
    chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("pend_mask", 32'(pend_mask), 32'(ep));
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
    end
    chk("lock_timeout", 32'(lock_timeout), 32'(e_to));
    if (wr_en) rf_dut[wr_addr] = wr_data;
    e_to    = 0;
    e_wr_en = (w >= 0);
    if (w >= 0) begin
      e_addr = int'(req_addr[w*AW +: AW]);
      e_data = int'(req_data[w*DW +: DW]);
      e_gid  = w;
      m_ptr  = (w + 1) % NR;
      if (!m_locked) begin
        if (req_lock[w]) begin m_locked = 1; m_owner = w; m_idle = 0; end
      end else begin
        m_idle = 0;
        if (!req_lock[w]) m_locked = 0;
      end
    end else if (m_locked) begin
      m_idle++;
      if (m_idle == LM) begin
        m_locked = 0; e_to = 1; m_idle = 0; m_ptr = (m_owner + 1) % NR;
      end
    end
    last_xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    set_req(i, 1'b1, ($urandom_range(99) < 30), AW'($urandom_range(7)), DW'($urandom_range(255)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int rate [NR];
    vecs[0] = '{3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 8'h00, 3'd0, 8'h00};
    vecs[1] = '{3'b001, {3'd0, 3'd0, 3'd3}, 3'b001, 8'h08, 3'd3, 8'h40};
    vecs[2] = '{3'b010, {3'd0, 3'd5, 3'd0}, 3'b010, 8'h20, 3'd5, 8'h41};
    vecs[3] = '{3'b100, {3'd7, 3'd0, 3'd0}, 3'b100, 8'h80, 3'd7, 8'h42};
    vecs[4] = '{3'b110, {3'd2, 3'd1, 3'd0}, 3'b010, 8'h06, 3'd1, 8'h41};
    vecs[5] = '{3'b111, {3'd0, 3'd4, 3'd4}, 3'b001, 8'h11, 3'd4, 8'h40};
    vecs[6] = '{3'b101, {3'd6, 3'd2, 3'd6}, 3'b001, 8'h40, 3'd6, 8'h40};
    for (int r = 0; r < 8; r++) rf_dut[r] = '0;

    // Test 1: reset/idle, then async reset in the middle of a locked burst.
    do_reset();
    step();
    chk("t1_idle_wr_en", 32'(s_wr_en), 32'd0);
    chk("t1_idle_ready", 32'(s_ready), 32'd0);
    chk("t1_idle_pend", 32'(s_pend), 32'd0);
    set_req(int'(REQ_DBG), 1'b1, 1'b1, 3'd1, 8'h5A);
    step();
    set_req(int'(REQ_DBG), 1'b0, 1'b0, 3'd0, 8'h00);
    chk("t1_wr_en_before_rst", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_wr_en_in_rst", 32'(wr_en), 32'd0);
    do_reset();
    set_req(int'(REQ_ALU), 1'b1, 1'b0, 3'd4, 8'h44);
    step();
    chk("t1_arb_after_rst", 32'(s_ready), 32'b001);

    // Vector table: single transfers from a fresh reset.
    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < NR; i++)
        set_req(i, vecs[v].valid[i], 1'b0, vecs[v].addr[i*AW +: AW], DW'(8'h40 + i));
      step();
      chk("tbl_ready", 32'(s_ready), 32'(vecs[v].exp_ready));
      chk("tbl_pend", 32'(s_pend), 32'(vecs[v].exp_pend));
      req_valid = '0;
      step();
      chk("tbl_wr_en", 32'(s_wr_en), 32'(|vecs[v].valid));
      if (vecs[v].valid != 3'b000) begin
        chk("tbl_wr_addr", 32'(s_wr_addr), 32'(vecs[v].exp_addr));
        chk("tbl_wr_data", 32'(s_wr_data), 32'(vecs[v].exp_data));
      end
    end

    // Test 2: single ALU write.
    do_reset();
    set_req(int'(REQ_ALU), 1'b1, 1'b0, 3'd3, 8'hA5);
    step();
    set_req(int'(REQ_ALU), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("t2_wr_en", 32'(s_wr_en), 32'd1);
    chk("t2_wr_addr", 32'(s_wr_addr), 32'd3);
    chk("t2_wr_data", 32'(s_wr_data), 32'hA5);
    chk("t2_grant_id", 32'(s_gid), 32'd0);
    chk("t2_rf_r3", 32'(rf_dut[3]), 32'hA5);

    // Test 3: all three held valid for 6 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), DW'(8'h30 + i));
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t3_order", 32'(onehot_idx(s_ready)), 32'(c % NR));
      if (c > 0) chk("t3_no_gap", 32'(s_wr_en), 32'd1);
      for (int i = 0; i < NR; i++)
        if (last_xfer[i]) set_req(i, 1'b1, 1'b0, AW'(i), DW'(8'h50 + c));
    end
    req_valid = '0;
    step();
    chk("t3_last_wr", 32'(s_wr_en), 32'd1);

    // Test 4: DBG locked burst r0..r7 while ALU waits.
    do_reset();
    set_req(int'(REQ_DBG), 1'b1, 1'b1, 3'd0, 8'h10);
    step();
    chk("t4_first", 32'(s_ready), 32'b100);
    set_req(int'(REQ_ALU), 1'b1, 1'b0, 3'd6, 8'hEE);
    for (int r = 1; r < 8; r++) begin
      set_req(int'(REQ_DBG), 1'b1, (r < 7), AW'(r), DW'(8'h10 + r));
      step();
      chk("t4_dbg_only", 32'(s_ready), 32'b100);
    end
    set_req(int'(REQ_DBG), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("t4_alu_next", 32'(s_ready), 32'b001);
    set_req(int'(REQ_ALU), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    step();
    for (int r = 0; r < 8; r++)
      chk("t4_rf", 32'(rf_dut[r]), (r == 6) ? 32'hEE : 32'(8'h10 + r));

    // Test 5: locked owner goes idle, forced release after LOCK_MAX idle cycles.
    do_reset();
    set_req(int'(REQ_DBG), 1'b1, 1'b1, 3'd2, 8'h33);
    step();
    set_req(int'(REQ_DBG), 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(int'(REQ_ALU), 1'b1, 1'b0, 3'd4, 8'h44);
    pulses = 0;
    for (int k = 0; k < LM; k++) begin
      step();
      chk("t5_blocked", 32'(s_ready), 32'd0);
      pulses += int'(s_to);
    end
    step();
    chk("t5_alu_after_to", 32'(s_ready), 32'b001);
    chk("t5_pulse", 32'(s_to), 32'd1);
    pulses += int'(s_to);
    set_req(int'(REQ_ALU), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    pulses += int'(s_to);
    chk("t5_pulse_count", 32'(pulses), 32'd1);

    // Test 6: ALU and MEM both target r5.
    do_reset();
    set_req(int'(REQ_ALU), 1'b1, 1'b0, 3'd5, 8'h11);
    set_req(int'(REQ_MEM), 1'b1, 1'b0, 3'd5, 8'h22);
    step();
    chk("t6_alu_first", 32'(s_ready), 32'b001);
    chk("t6_pend5_a", 32'(s_pend[5]), 32'd1);
    set_req(int'(REQ_ALU), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("t6_mem_second", 32'(s_ready), 32'b010);
    chk("t6_pend5_b", 32'(s_pend[5]), 32'd1);
    set_req(int'(REQ_MEM), 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("t6_pend5_clear", 32'(s_pend[5]), 32'd0);
    chk("t6_rf_r5", 32'(rf_dut[5]), 32'h22);

    // Random traffic; DBG requests rarely so its locks tend to time out.
    do_reset();
    rate[0] = 50; rate[1] = 40; rate[2] = 6;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_xfer[i]) begin
          if ($urandom_range(99) < 50) new_req(i);
          else set_req(i, 1'b0, 1'b0, 3'd0, 8'h00);
        end else if (!req_valid[i] && ($urandom_range(99) < rate[i])) begin
          new_req(i);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
